// File: rtl/program_loader_if.sv
// Byte-stream ingress and program-memory write port of the program loader.
// The loader uses the slave side; a stream source or testbench uses the master side.
interface program_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_waddr;
    logic [DATA_W-1:0] pm_wdata;

    modport master (output byte_in, byte_valid,
                    input  byte_ready, pm_we, pm_waddr, pm_wdata);
    modport slave  (input  byte_in, byte_valid,
                    output byte_ready, pm_we, pm_waddr, pm_wdata);
endinterface

// File: rtl/program_loader.sv
// Program memory writer: parses a LEN / data / XOR-checksum byte frame, writes
// 16-bit words high byte first, and holds the CPU in reset while loading.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    program_loader_if.slave   bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t          state, nxt;
    logic [ADDR_W:0] len;
    logic [7:0]      csum;
    logic [ADDR_W:0] wc_next;
    logic            last_word;
    logic            len_bad;
    logic            start_ok;

    assign wc_next   = word_count + 1'b1;
    assign last_word = (wc_next == len);
    assign len_bad   = (bus.byte_in == 8'd0) || (bus.byte_in > DEPTH_B);
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign cpu_hold  = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Every byte-accepting state raises ready unconditionally, so valid alone
    // marks a transfer there.
    always_comb begin
        nxt            = state;
        bus.byte_ready = 1'b0;
        bus.pm_we      = 1'b0;
        busy           = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: if (start) nxt = S_LEN;
            S_LEN: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) nxt = len_bad ? S_ERR : S_HI;
            end
            S_HI: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) nxt = S_LO;
            end
            S_LO: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) nxt = S_WR;
            end
            S_WR: begin
                bus.pm_we = 1'b1;
                busy      = 1'b1;
                nxt       = last_word ? S_CHK : S_HI;
            end
            S_CHK: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) nxt = (bus.byte_in == csum) ? S_DONE : S_ERR;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len          <= '0;
            csum         <= '0;
            word_count   <= '0;
            bus.pm_waddr <= '0;
            bus.pm_wdata <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                error      <= 1'b0;
                word_count <= '0;
            end
            unique case (state)
                S_LEN: if (bus.byte_valid) begin
                    if (len_bad) error <= 1'b1;
                    else begin
                        len          <= bus.byte_in[ADDR_W:0];
                        csum         <= '0;
                        word_count   <= '0;
                        bus.pm_waddr <= '0;
                    end
                end
                S_HI: if (bus.byte_valid) begin
                    bus.pm_wdata[DATA_W-1:DATA_W-8] <= bus.byte_in;
                    csum <= csum ^ bus.byte_in;
                end
                S_LO: if (bus.byte_valid) begin
                    bus.pm_wdata[7:0] <= bus.byte_in;
                    csum <= csum ^ bus.byte_in;
                end
                S_WR: begin
                    word_count <= wc_next;
                    // Address parks on the final word so it never wraps past DEPTH-1.
                    if (!last_word) bus.pm_waddr <= bus.pm_waddr + 1'b1;
                end
                S_CHK: if (bus.byte_valid) begin
                    if (bus.byte_in == csum) done  <= 1'b1;
                    else                     error <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are parsed by a bench-side model
// into expected writes/outcome, and a negedge monitor checks every write strobe.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cpu_hold, busy, done, error;
    logic [5:0] word_count;

    program_loader_if #(.ADDR_W(5), .DATA_W(16)) bus ();

    program_loader #(.ADDR_W(5), .DATA_W(16), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_q[$];
    logic [7:0]  frame[$];
    int          wr_cnt;
    int          done_cnt;
    int          last_waddr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Every cycle: each write strobe must match the next modelled write, and
    // the stream must be closed while the strobe is up.
    always @(negedge clk) begin
        if (rst_n) begin
            check("hold_eq_busy", 32'(cpu_hold), 32'(busy));
            if (done) done_cnt++;
            if (bus.pm_we) begin
                wr_cnt++;
                last_waddr = int'(bus.pm_waddr);
                check("ready_in_wr", 32'(bus.byte_ready), 32'd0);
                if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else check("write", 32'({bus.pm_waddr, bus.pm_wdata}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit acc;
        int n;
        if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        n = 0;
        forever begin
            acc = bus.byte_ready;
            @(negedge clk);
            if (acc) break;
            n++;
            if (n > 200) begin
                check("byte_timeout", 32'd1, 32'd0);
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    // Model: derive the outcome of the frame from the framing rules alone.
    task automatic run_frame(input bit stall, input string tag);
        int         n;
        int         exp_wr;
        bit         ok;
        logic [7:0] x;
        exp_q.delete();
        wr_cnt   = 0;
        done_cnt = 0;
        n = int'(frame[0]);
        exp_wr = 0;
        ok = 1'b0;
        if (n >= 1 && n <= 32) begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({5'(i), frame[1+2*i], frame[2+2*i]});
                x = x ^ frame[1+2*i] ^ frame[2+2*i];
            end
            exp_wr = n;
            ok = (x == frame[2*n+1]);
        end
        do_start();
        check({tag, "_err_cleared"}, 32'(error), 32'd0);
        foreach (frame[i]) send_byte(frame[i], stall);
        repeat (3) @(negedge clk);
        check({tag, "_writes"},     32'(wr_cnt),     32'(exp_wr));
        check({tag, "_done_pulse"}, 32'(done_cnt),   ok ? 32'd1 : 32'd0);
        check({tag, "_error"},      32'(error),      ok ? 32'd0 : 32'd1);
        check({tag, "_word_count"}, 32'(word_count), 32'(exp_wr));
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_left_over"},  32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_we"},    32'(bus.pm_we),      32'd0);
        check({tag, "_waddr"}, 32'(bus.pm_waddr),   32'd0);
        check({tag, "_wdata"}, 32'(bus.pm_wdata),   32'd0);
        check({tag, "_hold"},  32'(cpu_hold),       32'd0);
        check({tag, "_busy"},  32'(busy),           32'd0);
        check({tag, "_done"},  32'(done),           32'd0);
        check({tag, "_error"}, 32'(error),          32'd0);
        check({tag, "_wc"},    32'(word_count),     32'd0);
    endtask

    initial begin
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // N=2: writes 2810@0, 3900@1, checksum 01
        frame = '{8'h02, 8'h28, 8'h10, 8'h39, 8'h00, 8'h01};
        run_frame(1'b0, "n2");
        check("n2_lit_last_addr", 32'(last_waddr), 32'd1);
        check("n2_lit_wc", 32'(word_count), 32'd2);

        // Bytes offered in DONE are refused
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            check("done_refuses", 32'(bus.byte_ready), 32'd0);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;

        // Full load, 32 words
        begin
            logic [7:0] x;
            x = 8'h00;
            frame = '{8'd32};
            for (int i = 0; i < 32; i++) begin
                frame.push_back(8'(i * 7 + 1));
                frame.push_back(8'(~i));
                x = x ^ 8'(i * 7 + 1) ^ 8'(~i);
            end
            frame.push_back(x);
        end
        run_frame(1'b0, "n32");
        check("n32_lit_last_addr", 32'(last_waddr), 32'd31);
        check("n32_lit_wc", 32'(word_count), 32'd32);

        // Bad checksum: 05^10 = 15, send 00
        frame = '{8'h01, 8'h05, 8'h10, 8'h00};
        run_frame(1'b0, "badchk");
        check("badchk_lit_error", 32'(error), 32'd1);

        // Bad lengths
        frame = '{8'h00};
        run_frame(1'b0, "len0");
        frame = '{8'd33};
        run_frame(1'b0, "len33");
        check("len33_lit_writes", 32'(wr_cnt), 32'd0);

        // Stalled delivery of the N=2 frame and of a 5-word frame
        frame = '{8'h02, 8'h28, 8'h10, 8'h39, 8'h00, 8'h01};
        run_frame(1'b1, "n2_stall");
        frame = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                  8'h77, 8'h88, 8'h99, 8'hAA, 8'h11};
        run_frame(1'b1, "n5_stall");

        // Reset mid-load
        frame = '{8'h04, 8'hDE, 8'hAD, 8'hBE};
        exp_q.delete();
        exp_q.push_back({5'd0, 16'hDEAD});
        do_start();
        foreach (frame[i]) send_byte(frame[i], 1'b0);
        check("mid_hold", 32'(cpu_hold), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle_ready", 32'(bus.byte_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
